// File: rtl/four_bit_seq_divider.sv
// Multi-cycle unsigned 4-bit restoring divider built around one 4-bit adder-subtractor.
// Define DIV_SIGNED_EN to add the signed_op port for two's-complement operands.

module four_bit_adder_subtractor (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       subtract,
  output logic [3:0] result,
  output logic       cout
);
  logic [4:0] sum;

  // Subtraction as a + ~b + 1; cout=1 then means no borrow.
  assign sum    = {1'b0, a} + {1'b0, b ^ {4{subtract}}} + {4'b0000, subtract};
  assign result = sum[3:0];
  assign cout   = sum[4];
endmodule

module four_bit_seq_divider #(
  parameter logic [3:0] DZ_QUOTIENT = 4'hF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] dividend,
  input  logic [3:0] divisor,
`ifdef DIV_SIGNED_EN
  input  logic       signed_op,
`endif
  output logic       busy,
  output logic       done,
  output logic [3:0] quotient,
  output logic [3:0] remainder,
  output logic       div_by_zero
);
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0] state_q, state_d;
  logic [3:0] r_q, r_d;
  logic [3:0] q_q, q_d;
  logic [3:0] d_q, d_d;
  logic [1:0] count_q, count_d;
  logic [3:0] quotient_q, quotient_d;
  logic [3:0] remainder_q, remainder_d;
  logic       dz_q, dz_d;

  logic [3:0] shifted;
  logic [3:0] diff;
  logic       no_borrow;
  logic       take;
  logic [3:0] q_next;
  logic [3:0] r_next;
  logic [3:0] dividend_mag;
  logic [3:0] divisor_mag;

`ifdef DIV_SIGNED_EN
  logic qneg_q, qneg_d;
  logic rneg_q, rneg_d;
`endif

  four_bit_adder_subtractor u_addsub (
    .a        (shifted),
    .b        (d_q),
    .subtract (1'b1),
    .result   (diff),
    .cout     (no_borrow)
  );

  // r_q[3] is the bit shifted out of the 5-bit partial remainder {R, Q[3]}.
  assign shifted = {r_q[2:0], q_q[3]};
  assign take    = r_q[3] | no_borrow;
  assign q_next  = {q_q[2:0], take};
  assign r_next  = take ? diff : shifted;

`ifdef DIV_SIGNED_EN
  assign dividend_mag = (signed_op && dividend[3]) ? 4'd0 - dividend : dividend;
  assign divisor_mag  = (signed_op && divisor[3])  ? 4'd0 - divisor  : divisor;
`else
  assign dividend_mag = dividend;
  assign divisor_mag  = divisor;
`endif

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    q_d         = q_q;
    d_d         = d_q;
    count_d     = count_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dz_d        = dz_q;
`ifdef DIV_SIGNED_EN
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
`endif
    case (state_q)
      StIdle: begin
        if (start) begin
          if (divisor != 4'd0) begin
            d_d     = divisor_mag;
            q_d     = dividend_mag;
            r_d     = 4'd0;
            count_d = 2'd3;
            dz_d    = 1'b0;
`ifdef DIV_SIGNED_EN
            qneg_d  = signed_op & (dividend[3] ^ divisor[3]);
            rneg_d  = signed_op & dividend[3];
`endif
            state_d = StRun;
          end else begin
            quotient_d  = DZ_QUOTIENT;
            remainder_d = dividend;
            dz_d        = 1'b1;
            state_d     = StDone;
          end
        end
      end
      StRun: begin
        r_d     = r_next;
        q_d     = q_next;
        count_d = count_q - 2'd1;
        if (count_q == 2'd0) begin
          state_d = StDone;
`ifdef DIV_SIGNED_EN
          quotient_d  = qneg_q ? 4'd0 - q_next : q_next;
          remainder_d = rneg_q ? 4'd0 - r_next : r_next;
`else
          quotient_d  = q_next;
          remainder_d = r_next;
`endif
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      r_q         <= 4'd0;
      q_q         <= 4'd0;
      d_q         <= 4'd0;
      count_q     <= 2'd0;
      quotient_q  <= 4'd0;
      remainder_q <= 4'd0;
      dz_q        <= 1'b0;
`ifdef DIV_SIGNED_EN
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      q_q         <= q_d;
      d_q         <= d_d;
      count_q     <= count_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dz_q        <= dz_d;
`ifdef DIV_SIGNED_EN
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
`endif
    end
  end

  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dz_q;
endmodule
